load_store_unit: RTL and testbench

- CPU-side initiator for a word-organised data memory that has a synchronous read port.
- Accepts one load/store request at a time from the MEM stage over a valid/ready handshake.
- Converts each request into one or two word-aligned memory accesses with byte enables. A misaligned access that crosses a word boundary is split in two.
- Reassembles and zero/sign-extends load data, then signals completion with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/load_store_unit_if.sv | 47 ++++
 rtl/lsu_lane_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_pkg : width encodings, FSM states and byte-count helpers shared by     |
// |           the load/store unit and its lane-alignment datapath.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lsu_pkg;

   localparam logic [1:0] WIDTH_B    = 2'b00;
   localparam logic [1:0] WIDTH_H    = 2'b01;
   localparam logic [1:0] WIDTH_W    = 2'b10;
   localparam logic [1:0] WIDTH_NONE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FIRST  = 2'd1,
      ST_SECOND = 2'd2,
      ST_RESP   = 2'd3
   } lsu_state_e;

   function automatic logic [2:0] byte_count(input logic [1:0] width);
      logic [2:0] n;
      case (width)
         WIDTH_B: n = 3'd1;
         WIDTH_H: n = 3'd2;
         WIDTH_W: n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   // An access spills into the next word when it runs past byte lane 3.
   function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] n);
      return (({1'b0, off} + n) > 3'd4);
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_req_if / lsu_mem_if : MEM-stage request/response bus and word-memory   |
// |                           bus of the load/store unit.                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lsu_req_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_width;
   logic        req_write;
   logic        req_sign_extend;
   logic        resp_valid;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_addr, req_wdata, req_width, req_write, req_sign_extend,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, req_width, req_write, req_sign_extend,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

interface lsu_mem_if;
   logic        mem_en;
   logic        mem_we;
   logic [29:0] mem_word_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output mem_en, mem_we, mem_word_addr, mem_be, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      input  mem_en, mem_we, mem_word_addr, mem_be, mem_wdata,
      output mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_lane_align : combinational byte-lane steering for stores and          |
// |                  reassembly plus zero/sign extension for loads.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lsu_lane_align
   import lsu_pkg::*;
(
   input  wire logic [1:0]  i_off,
   input  wire logic [2:0]  i_n,
   input  wire logic [31:0] i_wdata,
   input  wire logic        i_half,
   output logic      [3:0]  o_be,
   output logic      [31:0] o_wdata,
   input  wire logic [31:0] i_lo,
   input  wire logic [31:0] i_hi,
   input  wire logic        i_sign,
   output logic      [31:0] o_rdata
);

   logic [3:0]  w_mask4;
   logic [31:0] w_dmask32;
   logic [4:0]  w_shamt;
   logic [7:0]  w_be8;
   logic [63:0] w_wr64;
   logic [63:0] w_rd64;
   logic [31:0] w_rd_raw;
   logic        w_msb;

   always_comb begin
      w_mask4 = 4'b0000;
      case (i_n)
         3'd1:    w_mask4 = 4'b0001;
         3'd2:    w_mask4 = 4'b0011;
         3'd4:    w_mask4 = 4'b1111;
         default: w_mask4 = 4'b0000;
      endcase
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_dmask32[8*gi +: 8] = {8{w_mask4[gi]}};
   end

   assign w_shamt = {i_off, 3'b000};

   // The 8-bit / 64-bit shifted images hold both words of a split access:
   // the low half goes out first, the high half on the second access.
   assign w_be8   = {4'b0000, w_mask4} << i_off;
   assign w_wr64  = {32'h0, i_wdata & w_dmask32} << w_shamt;
   assign o_be    = i_half ? w_be8[7:4]    : w_be8[3:0];
   assign o_wdata = i_half ? w_wr64[63:32] : w_wr64[31:0];

   assign w_rd64   = {i_hi, i_lo} >> w_shamt;
   assign w_rd_raw = w_rd64[31:0];

   always_comb begin
      w_msb = 1'b0;
      case (i_n)
         3'd1:    w_msb = w_rd_raw[7];
         3'd2:    w_msb = w_rd_raw[15];
         3'd4:    w_msb = w_rd_raw[31];
         default: w_msb = 1'b0;
      endcase
   end

   assign o_rdata = (w_rd_raw & w_dmask32) | (~w_dmask32 & {32{i_sign & w_msb}});

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit : splits MEM-stage loads/stores into one or two aligned   |
// |                   word accesses and returns extended load data.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_store_unit
   import lsu_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  rst,
   lsu_req_if.slave   req_bus,
   lsu_mem_if.master  mem_bus
);

   lsu_state_e  r_state;
   lsu_state_e  w_state_nxt;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_width;
   logic        r_write;
   logic        r_sign;
   logic [31:0] r_lo;

   logic [1:0]  w_off;
   logic [2:0]  w_n;
   logic        w_split;
   logic        w_accept;
   logic        w_half;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ld_lo;
   logic [31:0] w_ld_hi;
   logic [31:0] w_rdata;

   assign w_off    = r_addr[1:0];
   assign w_n      = byte_count(r_width);
   assign w_split  = crosses_word(w_off, w_n);
   assign w_accept = req_bus.req_valid && (r_state == ST_IDLE);
   assign w_half   = (r_state == ST_SECOND);

   // Non-split loads see their only word on mem_rdata in RESP; split loads
   // see word1 there and word0 in the captured lo register.
   assign w_ld_lo = w_split ? r_lo           : mem_bus.mem_rdata;
   assign w_ld_hi = w_split ? mem_bus.mem_rdata : 32'h0;

   lsu_lane_align u_align (
      .i_off   (w_off),
      .i_n     (w_n),
      .i_wdata (r_wdata),
      .i_half  (w_half),
      .o_be    (w_be),
      .o_wdata (w_wdata),
      .i_lo    (w_ld_lo),
      .i_hi    (w_ld_hi),
      .i_sign  (r_sign),
      .o_rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= 32'h0;
         r_wdata <= 32'h0;
         r_width <= WIDTH_NONE;
         r_write <= 1'b0;
         r_sign  <= 1'b0;
         r_lo    <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_addr  <= req_bus.req_addr;
            r_wdata <= req_bus.req_wdata;
            r_width <= req_bus.req_width;
            r_write <= req_bus.req_write;
            r_sign  <= req_bus.req_sign_extend;
         end
         if (r_state == ST_SECOND) begin
            r_lo <= mem_bus.mem_rdata;
         end
      end
   end

   always_comb begin
      w_state_nxt            = r_state;
      req_bus.req_ready      = 1'b0;
      req_bus.resp_valid     = 1'b0;
      req_bus.resp_rdata     = 32'h0;
      mem_bus.mem_en         = 1'b0;
      mem_bus.mem_we         = 1'b0;
      mem_bus.mem_word_addr  = 30'h0;
      mem_bus.mem_be         = 4'b0000;
      mem_bus.mem_wdata      = 32'h0;

      case (r_state)
         ST_IDLE: begin
            req_bus.req_ready = 1'b1;
            if (req_bus.req_valid) begin
               w_state_nxt = (req_bus.req_width == WIDTH_NONE) ? ST_RESP : ST_FIRST;
            end
         end
         ST_FIRST: begin
            mem_bus.mem_en        = 1'b1;
            mem_bus.mem_we        = r_write;
            mem_bus.mem_word_addr = r_addr[31:2];
            mem_bus.mem_be        = w_be;
            mem_bus.mem_wdata     = w_wdata;
            w_state_nxt           = w_split ? ST_SECOND : ST_RESP;
         end
         ST_SECOND: begin
            mem_bus.mem_en        = 1'b1;
            mem_bus.mem_we        = r_write;
            mem_bus.mem_word_addr = r_addr[31:2] + 30'd1;
            mem_bus.mem_be        = w_be;
            mem_bus.mem_wdata     = w_wdata;
            w_state_nxt           = ST_RESP;
         end
         ST_RESP: begin
            req_bus.resp_valid = 1'b1;
            req_bus.resp_rdata = r_write ? 32'h0 : w_rdata;
            w_state_nxt        = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_store_unit : directed table, reset-abort sequence and random ops  |
// |                      against a byte-level memory model.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

   logic clk;
   logic rst;

   lsu_req_if req_bus ();
   lsu_mem_if mem_bus ();

   load_store_unit dut (
      .clk     (clk),
      .rst     (rst),
      .req_bus (req_bus),
      .mem_bus (mem_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem_arr [logic [29:0]];
   logic [7:0]  ref_mem [logic [31:0]];

   always @(posedge clk) begin
      if (mem_bus.mem_en) begin
         if (mem_bus.mem_we) begin
            logic [31:0] tmp;
            tmp = mem_arr.exists(mem_bus.mem_word_addr) ? mem_arr[mem_bus.mem_word_addr] : 32'h0;
            for (int b = 0; b < 4; b++)
               if (mem_bus.mem_be[b]) tmp[8*b +: 8] = mem_bus.mem_wdata[8*b +: 8];
            mem_arr[mem_bus.mem_word_addr] = tmp;
         end else begin
            mem_bus.mem_rdata <= mem_arr.exists(mem_bus.mem_word_addr) ?
                                 mem_arr[mem_bus.mem_word_addr] : 32'h0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [29:0] word, input logic [31:0] val);
      mem_arr[word] = val;
      for (int b = 0; b < 4; b++) ref_mem[{word, 2'(b)}] = val[8*b +: 8];
   endtask

   // Byte-at-a-time view of a request: walk the n bytes, group them by word.
   task automatic model(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] width, input logic write, input logic sign,
                        output logic [31:0] e_rd, output int e_lat, output int e_na,
                        output logic [29:0] e_w0, output logic [29:0] e_w1,
                        output logic [3:0] e_be0, output logic [3:0] e_be1,
                        output logic [31:0] e_wd0, output logic [31:0] e_wd1);
      int          n;
      int          lane;
      logic [29:0] wq [2];
      logic [3:0]  bq [2];
      logic [31:0] dq [2];
      logic [31:0] val;
      logic [31:0] a;
      n = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : (width == 2'b10) ? 4 : 0;
      e_na = 0;
      val  = 32'h0;
      for (int i = 0; i < 2; i++) begin wq[i] = '0; bq[i] = '0; dq[i] = '0; end
      for (int k = 0; k < n; k++) begin
         a    = addr + 32'(k);
         lane = int'(a[1:0]);
         if (e_na == 0 || wq[e_na-1] != a[31:2]) begin
            wq[e_na] = a[31:2];
            e_na++;
         end
         bq[e_na-1][lane]         = 1'b1;
         dq[e_na-1][8*lane +: 8]  = wdata[8*k +: 8];
         if (write) ref_mem[a] = wdata[8*k +: 8];
         else       val[8*k +: 8] = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
      end
      if (n > 0 && sign && val[8*n-1])
         for (int b = 8*n; b < 32; b++) val[b] = 1'b1;
      e_rd  = (write || n == 0) ? 32'h0 : val;
      e_lat = (n == 0) ? 1 : 1 + e_na;
      e_w0 = wq[0]; e_w1 = wq[1]; e_be0 = bq[0]; e_be1 = bq[1]; e_wd0 = dq[0]; e_wd1 = dq[1];
   endtask

   task automatic run_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] width, input logic write, input logic sign,
                         input logic [31:0] x_rd, input int x_lat, input int x_na,
                         input logic [29:0] x_w0, input logic [29:0] x_w1,
                         input logic [3:0] x_be0, input logic [3:0] x_be1,
                         input logic [31:0] x_wd0, input logic [31:0] x_wd1);
      int          got_lat;
      int          nacc;
      int          leak;
      logic [31:0] got_rd;
      logic [29:0] aw [2];
      logic [3:0]  ab [2];
      logic [31:0] ad [2];
      logic        awe [2];
      got_lat = 0; nacc = 0; leak = 0; got_rd = 32'h0;
      for (int i = 0; i < 2; i++) begin aw[i] = '0; ab[i] = '0; ad[i] = '0; awe[i] = 1'b0; end
      @(negedge clk);
      chk({tag, ".ready"}, 32'(req_bus.req_ready), 32'd1);
      req_bus.req_valid       = 1'b1;
      req_bus.req_addr        = addr;
      req_bus.req_wdata       = wdata;
      req_bus.req_width       = width;
      req_bus.req_write       = write;
      req_bus.req_sign_extend = sign;
      @(posedge clk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (mem_bus.mem_en) begin
            if (nacc < 2) begin
               aw[nacc] = mem_bus.mem_word_addr; ab[nacc] = mem_bus.mem_be;
               ad[nacc] = mem_bus.mem_wdata;     awe[nacc] = mem_bus.mem_we;
            end
            nacc++;
         end
         if (req_bus.resp_valid) begin
            got_lat = c;
            got_rd  = req_bus.resp_rdata;
            req_bus.req_valid = 1'b0;
            break;
         end
         if (req_bus.resp_rdata != 32'h0) leak++;
         // Requests presented while busy must be ignored.
         req_bus.req_valid       = 1'($urandom % 2);
         req_bus.req_addr        = $urandom;
         req_bus.req_wdata       = $urandom;
         req_bus.req_width       = 2'($urandom % 4);
         req_bus.req_write       = 1'($urandom % 2);
         req_bus.req_sign_extend = 1'($urandom % 2);
      end
      req_bus.req_valid = 1'b0;
      chk({tag, ".latency"}, 32'(got_lat), 32'(x_lat));
      chk({tag, ".rdata"}, got_rd, x_rd);
      chk({tag, ".n_access"}, 32'(nacc), 32'(x_na));
      chk({tag, ".rdata_quiet"}, 32'(leak), 32'd0);
      if (x_na >= 1) begin
         chk({tag, ".word0"}, 32'(aw[0]), 32'(x_w0));
         chk({tag, ".be0"},   32'(ab[0]), 32'(x_be0));
         chk({tag, ".wd0"},   ad[0], x_wd0);
         chk({tag, ".we0"},   32'(awe[0]), 32'(write));
      end
      if (x_na >= 2) begin
         chk({tag, ".word1"}, 32'(aw[1]), 32'(x_w1));
         chk({tag, ".be1"},   32'(ab[1]), 32'(x_be1));
         chk({tag, ".wd1"},   ad[1], x_wd1);
         chk({tag, ".we1"},   32'(awe[1]), 32'(write));
      end
   endtask

   task automatic run_model_op(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] width, input logic write, input logic sign);
      logic [31:0] e_rd, e_wd0, e_wd1;
      int          e_lat, e_na;
      logic [29:0] e_w0, e_w1;
      logic [3:0]  e_be0, e_be1;
      model(addr, wdata, width, write, sign, e_rd, e_lat, e_na, e_w0, e_w1, e_be0, e_be1, e_wd0, e_wd1);
      run_op(tag, addr, wdata, width, write, sign, e_rd, e_lat, e_na, e_w0, e_w1, e_be0, e_be1, e_wd0, e_wd1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  width;
      logic        write;
      logic        sign;
      logic [31:0] rdata;
      int          lat;
      int          na;
      logic [29:0] w0;
      logic [29:0] w1;
      logic [3:0]  be0;
      logic [3:0]  be1;
      logic [31:0] wd0;
      logic [31:0] wd1;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [31:0] d_rd, d_wd0, d_wd1;
      int          d_lat, d_na, resp_seen;
      logic [29:0] d_w0, d_w1;
      logic [3:0]  d_be0, d_be1;

      tbl[0]  = '{32'h0000_0103, 32'h1122_3344, 2'b00, 1'b0, 1'b1, 32'hFFFF_FF80, 2, 1, 30'h40, 30'h0, 4'b1000, 4'b0000, 32'h4400_0000, 32'h0};
      tbl[1]  = '{32'h0000_0103, 32'h1122_3344, 2'b00, 1'b0, 1'b0, 32'h0000_0080, 2, 1, 30'h40, 30'h0, 4'b1000, 4'b0000, 32'h4400_0000, 32'h0};
      tbl[2]  = '{32'h0000_0107, 32'h0,         2'b01, 1'b0, 1'b1, 32'hFFFF_8012, 3, 2, 30'h41, 30'h42, 4'b1000, 4'b0001, 32'h0, 32'h0};
      tbl[3]  = '{32'h0000_0107, 32'h0,         2'b01, 1'b0, 1'b0, 32'h0000_8012, 3, 2, 30'h41, 30'h42, 4'b1000, 4'b0001, 32'h0, 32'h0};
      tbl[4]  = '{32'hFFFF_FFFE, 32'h0,         2'b10, 1'b0, 1'b1, 32'h7788_5566, 3, 2, 30'h3FFF_FFFF, 30'h0, 4'b1100, 4'b0011, 32'h0, 32'h0};
      tbl[5]  = '{32'h0000_0040, 32'h0000_0055, 2'b11, 1'b0, 1'b1, 32'h0,         1, 0, 30'h0, 30'h0, 4'b0000, 4'b0000, 32'h0, 32'h0};
      tbl[6]  = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 32'h0,         2, 1, 30'h40, 30'h0, 4'b1111, 4'b0000, 32'hDEAD_BEEF, 32'h0};
      tbl[7]  = '{32'h0000_0102, 32'hAABB_CCDD, 2'b10, 1'b1, 1'b0, 32'h0,         3, 2, 30'h40, 30'h41, 4'b1100, 4'b0011, 32'hCCDD_0000, 32'h0000_AABB};
      tbl[8]  = '{32'h0000_0101, 32'h1234_56A5, 2'b00, 1'b1, 1'b1, 32'h0,         2, 1, 30'h40, 30'h0, 4'b0010, 4'b0000, 32'h0000_A500, 32'h0};
      tbl[9]  = '{32'h0000_0100, 32'h0,         2'b10, 1'b0, 1'b0, 32'hCCDD_A5EF, 2, 1, 30'h40, 30'h0, 4'b1111, 4'b0000, 32'h0, 32'h0};
      tbl[10] = '{32'h0000_0100, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b0, 32'h0,         1, 0, 30'h0, 30'h0, 4'b0000, 4'b0000, 32'h0, 32'h0};

      rst = 1'b1;
      req_bus.req_valid = 1'b0; req_bus.req_addr = '0; req_bus.req_wdata = '0;
      req_bus.req_width = 2'b00; req_bus.req_write = 1'b0; req_bus.req_sign_extend = 1'b0;
      mem_bus.mem_rdata = 32'h0;

      preload(30'h40, 32'h8011_2233);
      preload(30'h41, 32'h1200_0000);
      preload(30'h42, 32'h0000_0080);
      preload(30'h3FFF_FFFF, 32'h5566_1234);
      preload(30'h0, 32'hABCD_7788);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.req_ready",  32'(req_bus.req_ready),  32'd1);
      chk("reset.resp_valid", 32'(req_bus.resp_valid), 32'd0);
      chk("reset.resp_rdata", req_bus.resp_rdata,      32'd0);
      chk("reset.mem_bus",    {mem_bus.mem_en, mem_bus.mem_we, mem_bus.mem_be, 26'(mem_bus.mem_word_addr)}, 32'd0);
      chk("reset.mem_wdata",  mem_bus.mem_wdata,       32'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         // Keep the byte-level model in step with the table's stores.
         model(tbl[i].addr, tbl[i].wdata, tbl[i].width, tbl[i].write, tbl[i].sign,
               d_rd, d_lat, d_na, d_w0, d_w1, d_be0, d_be1, d_wd0, d_wd1);
         run_op($sformatf("vec%0d", i), tbl[i].addr, tbl[i].wdata, tbl[i].width, tbl[i].write,
                tbl[i].sign, tbl[i].rdata, tbl[i].lat, tbl[i].na, tbl[i].w0, tbl[i].w1,
                tbl[i].be0, tbl[i].be1, tbl[i].wd0, tbl[i].wd1);
      end

      // Reset while the second word of a split load is on the bus.
      @(negedge clk);
      req_bus.req_valid = 1'b1; req_bus.req_addr = 32'h0000_0102;
      req_bus.req_width = 2'b10; req_bus.req_write = 1'b0; req_bus.req_sign_extend = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_bus.req_valid = 1'b0;
      chk("abort.first_en", 32'(mem_bus.mem_en), 32'd1);
      @(negedge clk);
      chk("abort.second_word", {mem_bus.mem_en, 1'b0, mem_bus.mem_word_addr}, {1'b1, 1'b0, 30'h41});
      rst = 1'b1;
      @(negedge clk);
      chk("abort.mem_en",    32'(mem_bus.mem_en),     32'd0);
      chk("abort.req_ready", 32'(req_bus.req_ready),  32'd1);
      chk("abort.resp",      32'(req_bus.resp_valid), 32'd0);
      rst = 1'b0;
      resp_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (req_bus.resp_valid || mem_bus.mem_en) resp_seen++;
      end
      chk("abort.silent", 32'(resp_seen), 32'd0);
      run_model_op("after_abort", 32'h0000_0106, 32'h0, 2'b01, 1'b0, 1'b1);

      for (int r = 0; r < 150; r++) begin
         logic [31:0] ra;
         ra = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 + ($urandom % 8) : 32'h0000_0100 + ($urandom % 32);
         run_model_op($sformatf("rnd%0d", r), ra, $urandom, 2'($urandom % 4),
                      1'($urandom % 2), 1'($urandom % 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
